// File: rtl/ctrl_stage_pipe_if.sv
// Bundles the decoded control word from ID together with the per-stage EX/MEM/WB
// controls and the retired-instruction counter.
interface ctrl_stage_pipe_if #(
    parameter int CTRL_W = 9,
    parameter int EXE_W  = 4,
    parameter int DEST_W = 4,
    parameter int CNT_W  = 16
);
    logic [CTRL_W-1:0] ctrlIn;
    logic [DEST_W-1:0] destIn;
    logic              condPass;
    logic              freeze;
    logic              flush;

    logic [EXE_W-1:0]  exeCmdEx;
    logic              statusEnEx;
    logic              branchTakEx;
    logic              wbEnEx;
    logic [DEST_W-1:0] destEx;
    logic              memREnMem;
    logic              memWEnMem;
    logic              wbEnMem;
    logic [DEST_W-1:0] destMem;
    logic              wbEnWb;
    logic              wbSelMemWb;
    logic [DEST_W-1:0] destWb;
    logic [CNT_W-1:0]  retiredCnt;

    modport master (
        output ctrlIn, destIn, condPass, freeze, flush,
        input  exeCmdEx, statusEnEx, branchTakEx, wbEnEx, destEx,
        input  memREnMem, memWEnMem, wbEnMem, destMem,
        input  wbEnWb, wbSelMemWb, destWb, retiredCnt
    );

    modport slave (
        input  ctrlIn, destIn, condPass, freeze, flush,
        output exeCmdEx, statusEnEx, branchTakEx, wbEnEx, destEx,
        output memREnMem, memWEnMem, wbEnMem, destMem,
        output wbEnWb, wbSelMemWb, destWb, retiredCnt
    );
endinterface

// File: rtl/ctrl_stage_pipe.sv
// Carries the ID-stage control word through EX, MEM and WB pipeline registers,
// inserting bubbles on freeze, flush or failed condition, and counts retirements.
module ctrl_stage_pipe #(
    parameter int CTRL_W = 9,
    parameter int EXE_W  = 4,
    parameter int DEST_W = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clock,
    input  logic              reset,
    ctrl_stage_pipe_if.slave  bus
);
    localparam int WB_BIT  = CTRL_W - 1;
    localparam int MR_BIT  = CTRL_W - 2;
    localparam int MW_BIT  = CTRL_W - 3;
    localparam int EXE_LSB = 2;
    localparam int BR_BIT  = 1;
    localparam int ST_BIT  = 0;

    logic              w_ex_load;
    logic [CTRL_W-1:0] w_ex_ctrl;
    logic [DEST_W-1:0] w_ex_dest;

    logic              r_ex_valid;
    logic [CTRL_W-1:0] r_ex_ctrl;
    logic [DEST_W-1:0] r_ex_dest;

    logic              r_mem_valid;
    logic              r_mem_wben;
    logic              r_mem_memren;
    logic              r_mem_memwen;
    logic [DEST_W-1:0] r_mem_dest;

    logic              r_wb_valid;
    logic              r_wb_wben;
    logic              r_wb_memren;
    logic [DEST_W-1:0] r_wb_dest;

    logic [CNT_W-1:0]  r_retired_cnt;

    // Bubbles are zeroed at load time, so every stored enable is already
    // valid-qualified and the outputs can come straight from flops.
    assign w_ex_load = bus.condPass & ~bus.freeze & ~bus.flush;
    assign w_ex_ctrl = w_ex_load ? bus.ctrlIn : '0;
    assign w_ex_dest = w_ex_load ? bus.destIn : '0;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_ex_valid    <= 1'b0;
            r_ex_ctrl     <= '0;
            r_ex_dest     <= '0;
            r_mem_valid   <= 1'b0;
            r_mem_wben    <= 1'b0;
            r_mem_memren  <= 1'b0;
            r_mem_memwen  <= 1'b0;
            r_mem_dest    <= '0;
            r_wb_valid    <= 1'b0;
            r_wb_wben     <= 1'b0;
            r_wb_memren   <= 1'b0;
            r_wb_dest     <= '0;
            r_retired_cnt <= '0;
        end else begin
            r_ex_valid    <= w_ex_load;
            r_ex_ctrl     <= w_ex_ctrl;
            r_ex_dest     <= w_ex_dest;

            r_mem_valid   <= r_ex_valid;
            r_mem_wben    <= r_ex_ctrl[WB_BIT];
            r_mem_memren  <= r_ex_ctrl[MR_BIT];
            r_mem_memwen  <= r_ex_ctrl[MW_BIT];
            r_mem_dest    <= r_ex_dest;

            r_wb_valid    <= r_mem_valid;
            r_wb_wben     <= r_mem_wben;
            r_wb_memren   <= r_mem_memren;
            r_wb_dest     <= r_mem_dest;

            // Wraps silently at the top of the range.
            if (r_wb_valid)
                r_retired_cnt <= r_retired_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign bus.exeCmdEx    = r_ex_ctrl[EXE_LSB +: EXE_W];
    assign bus.statusEnEx  = r_ex_ctrl[ST_BIT];
    assign bus.branchTakEx = r_ex_ctrl[BR_BIT];
    assign bus.wbEnEx      = r_ex_ctrl[WB_BIT];
    assign bus.destEx      = r_ex_dest;

    assign bus.memREnMem   = r_mem_memren;
    assign bus.memWEnMem   = r_mem_memwen;
    assign bus.wbEnMem     = r_mem_wben;
    assign bus.destMem     = r_mem_dest;

    assign bus.wbEnWb      = r_wb_wben;
    assign bus.wbSelMemWb  = r_wb_memren;
    assign bus.destWb      = r_wb_dest;

    assign bus.retiredCnt  = r_retired_cnt;
endmodule

// File: tb/tb_ctrl_stage_pipe.sv
// Scoreboard bench for ctrl_stage_pipe: each driven ID word pushes its expected
// stage entry; entries are compared as they show up in EX, MEM and WB.
module tb_ctrl_stage_pipe;
    logic clock = 1'b0;
    logic reset = 1'b0;

    always #5 clock = ~clock;

    ctrl_stage_pipe_if bus_if ();

    ctrl_stage_pipe dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus_if.slave)
    );

    typedef struct packed {
        logic       v;
        logic [3:0] exe;
        logic       st;
        logic       br;
        logic       wb;
        logic       mr;
        logic       mw;
        logic [3:0] dest;
    } ent_t;

    ent_t        sb[$];
    logic [15:0] exp_cnt = 16'h0000;
    int          n_checks = 0;
    int          n_errors = 0;

    localparam logic [8:0] C_ADD = 9'b100_0010_00;
    localparam logic [8:0] C_LDR = 9'b110_0010_01;
    localparam logic [8:0] C_STR = 9'b001_0010_00;
    localparam logic [8:0] C_BR  = 9'b000_0000_10;

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic ent_t make_ent(input logic [8:0] c, input logic [3:0] d, input logic ld);
        ent_t e;
        e = '0;
        if (ld) begin
            e.v    = 1'b1;
            e.wb   = c[8];
            e.mr   = c[7];
            e.mw   = c[6];
            e.exe  = c[5:2];
            e.br   = c[1];
            e.st   = c[0];
            e.dest = d;
        end
        return e;
    endfunction

    task automatic seed_bubbles();
        sb.delete();
        repeat (3) sb.push_back(ent_t'(0));
    endtask

    // One clock: drive ID inputs, advance, then compare all stages against the scoreboard.
    task automatic step(input logic [8:0] c, input logic [3:0] d, input logic cp,
                        input logic fz, input logic fl, input logic rst);
        ent_t ex_e, mem_e, wb_e;
        reset           = rst;
        bus_if.ctrlIn   = c;
        bus_if.destIn   = d;
        bus_if.condPass = cp;
        bus_if.freeze   = fz;
        bus_if.flush    = fl;
        sb.push_back(make_ent(c, d, cp & ~fz & ~fl));
        @(posedge clock);
        #1;
        if (rst) begin
            seed_bubbles();
            exp_cnt = 16'h0000;
        end else begin
            if (sb[0].v) exp_cnt = exp_cnt + 16'h0001;
            void'(sb.pop_front());
        end
        ex_e  = sb[2];
        mem_e = sb[1];
        wb_e  = sb[0];
        chk_eq("exeCmdEx",    32'(bus_if.exeCmdEx),    32'(ex_e.exe));
        chk_eq("statusEnEx",  32'(bus_if.statusEnEx),  32'(ex_e.st));
        chk_eq("branchTakEx", 32'(bus_if.branchTakEx), 32'(ex_e.br));
        chk_eq("wbEnEx",      32'(bus_if.wbEnEx),      32'(ex_e.wb));
        chk_eq("destEx",      32'(bus_if.destEx),      32'(ex_e.dest));
        chk_eq("memREnMem",   32'(bus_if.memREnMem),   32'(mem_e.mr));
        chk_eq("memWEnMem",   32'(bus_if.memWEnMem),   32'(mem_e.mw));
        chk_eq("wbEnMem",     32'(bus_if.wbEnMem),     32'(mem_e.wb));
        chk_eq("destMem",     32'(bus_if.destMem),     32'(mem_e.dest));
        chk_eq("wbEnWb",      32'(bus_if.wbEnWb),      32'(wb_e.wb));
        chk_eq("wbSelMemWb",  32'(bus_if.wbSelMemWb),  32'(wb_e.mr));
        chk_eq("destWb",      32'(bus_if.destWb),      32'(wb_e.dest));
        chk_eq("retiredCnt",  32'(bus_if.retiredCnt),  32'(exp_cnt));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(9'h000, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        bus_if.ctrlIn   = '0;
        bus_if.destIn   = '0;
        bus_if.condPass = 1'b0;
        bus_if.freeze   = 1'b0;
        bus_if.flush    = 1'b0;
        seed_bubbles();

        // Reset state
        step(9'h000, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(9'h000, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1);

        // ADD then drain: WB selects ALU, counter reaches 1 one edge after WB
        step(C_ADD, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(4);
        chk_eq("add_retired", 32'(bus_if.retiredCnt), 32'd1);

        // LDR: status enable in EX, memory read in MEM, memory select in WB
        step(C_LDR, 4'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(4);

        // STR frozen on its first cycle, then accepted
        step(C_STR, 4'd7, 1'b1, 1'b1, 1'b0, 1'b0);
        step(C_STR, 4'd7, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(4);

        // Branch followed by a flushed ADD: only the branch retires
        step(C_BR,  4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk_eq("branch_taken", 32'(bus_if.branchTakEx), 32'd1);
        step(C_ADD, 4'd9, 1'b1, 1'b0, 1'b1, 1'b0);
        chk_eq("branch_one_cycle", 32'(bus_if.branchTakEx), 32'd0);
        idle(4);

        // condPass=0, and freeze+flush together, both bubble
        step(C_ADD, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        step(C_LDR, 4'd4, 1'b1, 1'b1, 1'b1, 1'b0);
        idle(4);

        // Undefined opcode with condPass=1 still retires
        step(9'b100_0000_00, 4'd11, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(4);

        // Reset with all three stages valid clears everything
        step(C_ADD, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        step(C_LDR, 4'd2, 1'b1, 1'b0, 1'b0, 1'b0);
        step(C_STR, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0);
        step(C_ADD, 4'd4, 1'b1, 1'b0, 1'b0, 1'b1);
        chk_eq("reset_wbEnWb", 32'(bus_if.wbEnWb), 32'd0);
        idle(3);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            step(9'($urandom), 4'($urandom),
                 ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 99) == 0));
        end

        // Counter wrap: 65535 retirements reach FFFF, one more wraps to 0
        step(9'h000, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 65538; i++) step(C_ADD, 4'd6, 1'b1, 1'b0, 1'b0, 1'b0);
        chk_eq("cnt_ffff", 32'(bus_if.retiredCnt), 32'h0000_FFFF);
        step(C_ADD, 4'd6, 1'b1, 1'b0, 1'b0, 1'b0);
        chk_eq("cnt_wrap", 32'(bus_if.retiredCnt), 32'h0000_0000);
        idle(4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
